// File: rtl/acs_64.sv
// Add-compare-select stage for a K=7 rate-1/2 Viterbi decoder: 64 saturating path metrics with periodic normalization.
// Optional feature: define ACS_BEST_STATE_EN to add the registered best_state output.
`timescale 1ns/1ps

module acs_64 #(
    parameter int PM_W      = 7,
    parameter int INIT_BIAS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 bm_valid,
    input  logic [255:0]         bm_bus,
    output logic                 dec_valid,
    output logic [63:0]          dec,
    output logic                 norm_pulse,
    output logic [64*PM_W-1:0]   pm_bus
`ifdef ACS_BEST_STATE_EN
    ,
    output logic [5:0]           best_state
`endif
);

    localparam logic [PM_W-1:0] PM_INIT = PM_W'(INIT_BIAS);
    localparam logic [PM_W-1:0] PM_MAX  = '1;

    logic [PM_W-1:0] pm      [64];
    logic [PM_W-1:0] cand0   [64];
    logic [PM_W-1:0] cand1   [64];
    logic [PM_W-1:0] sel_pm  [64];
    logic [PM_W-1:0] next_pm [64];
    logic [63:0]     sel_dec;
    logic            all_high;

    // One extra bit catches the carry; anything past the metric range clamps to all-ones.
    function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] m, input logic [1:0] b);
        logic [PM_W:0] sum;
        sum = {1'b0, m} + {{(PM_W-1){1'b0}}, b};
        return sum[PM_W] ? PM_MAX : sum[PM_W-1:0];
    endfunction

    // NOTE: every comb output gets a default before the loop so no latch is inferred.
    always_comb begin
        all_high = 1'b1;
        sel_dec  = '0;
        for (int j = 0; j < 64; j++) begin
            cand0[j]   = sat_add(pm[{j[4:0], 1'b0}], bm_bus[4*j +: 2]);
            cand1[j]   = sat_add(pm[{j[4:0], 1'b1}], bm_bus[4*j+2 +: 2]);
            sel_dec[j] = cand1[j] < cand0[j];
            sel_pm[j]  = sel_dec[j] ? cand1[j] : cand0[j];
            all_high   = all_high & sel_pm[j][PM_W-1];
        end
    end

    // Clearing the shared MSB subtracts 2^(PM_W-1) from every metric and keeps differences intact.
    always_comb begin
        for (int j = 0; j < 64; j++) begin
            next_pm[j] = sel_pm[j];
            if (all_high)
                next_pm[j][PM_W-1] = 1'b0;
        end
    end

`ifdef ACS_BEST_STATE_EN
    logic [5:0]      best_idx;
    logic [PM_W-1:0] best_val;

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        best_idx = '0;
        best_val = next_pm[0];
        for (int j = 1; j < 64; j++) begin
            if (next_pm[j] < best_val) begin
                best_val = next_pm[j];
                best_idx = 6'(j);
            end
        end
    end
`endif

    // NOTE: state uses non-blocking assignments so all 64 metrics update from the same old values.
    // NOTE: the metric array is a register bank, not a RAM, so it is reset like any other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < 64; j++)
                pm[j] <= (j == 0) ? '0 : PM_INIT;
            dec        <= '0;
            dec_valid  <= 1'b0;
            norm_pulse <= 1'b0;
`ifdef ACS_BEST_STATE_EN
            best_state <= '0;
`endif
        end else if (start) begin
            for (int j = 0; j < 64; j++)
                pm[j] <= (j == 0) ? '0 : PM_INIT;
            dec        <= '0;
            dec_valid  <= 1'b0;
            norm_pulse <= 1'b0;
`ifdef ACS_BEST_STATE_EN
            best_state <= '0;
`endif
        end else if (bm_valid) begin
            for (int j = 0; j < 64; j++)
                pm[j] <= next_pm[j];
            dec        <= sel_dec;
            dec_valid  <= 1'b1;
            norm_pulse <= all_high;
`ifdef ACS_BEST_STATE_EN
            best_state <= best_idx;
`endif
        end else begin
            dec_valid  <= 1'b0;
            norm_pulse <= 1'b0;
        end
    end

    always_comb begin
        pm_bus = '0;
        for (int j = 0; j < 64; j++)
            pm_bus[PM_W*j +: PM_W] = pm[j];
    end

endmodule

// File: tb/tb_acs_64.sv
// Self-checking bench for acs_64: directed vector table, normalization and reset sequences, random run against a metric model.
`timescale 1ns/1ps

module tb_acs_64;

    localparam int PM_W      = 7;
    localparam int INIT_BIAS = 16;
    localparam int NS        = 64;
    localparam int BUS_W     = NS * PM_W;
    localparam int HALF      = 1 << (PM_W - 1);
    localparam int MAXPM     = (1 << PM_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               bm_valid;
    logic [255:0]       bm_bus;
    logic               dec_valid;
    logic [63:0]        dec;
    logic               norm_pulse;
    logic [BUS_W-1:0]   pm_bus;
`ifdef ACS_BEST_STATE_EN
    logic [5:0]         best_state;
`endif

    always #5 clk = ~clk;

    acs_64 #(.PM_W(PM_W), .INIT_BIAS(INIT_BIAS)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bm_valid   (bm_valid),
        .bm_bus     (bm_bus),
        .dec_valid  (dec_valid),
        .dec        (dec),
        .norm_pulse (norm_pulse),
        .pm_bus     (pm_bus)
`ifdef ACS_BEST_STATE_EN
        ,
        .best_state (best_state)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: metrics as plain integers, updated from the trellis rules.
    int         m_pm [NS];
    logic [63:0] m_dec;
    logic       m_dv;
    logic       m_np;
    int         m_best;

    typedef struct {
        bit           st;
        bit           v;
        logic [255:0] bm;
        logic         exp_dv;
        logic [63:0]  exp_dec;
        logic         exp_np;
        int           pm0;
        int           pm1;
        int           pm32;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int dut_pm(input int j);
        return int'(pm_bus[PM_W*j +: PM_W]);
    endfunction

    function automatic logic [BUS_W-1:0] model_bus();
        logic [BUS_W-1:0] r;
        r = '0;
        for (int j = 0; j < NS; j++)
            r[PM_W*j +: PM_W] = PM_W'(m_pm[j]);
        return r;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < NS; j++)
            m_pm[j] = (j == 0) ? 0 : INIT_BIAS;
        m_dec  = '0;
        m_dv   = 1'b0;
        m_np   = 1'b0;
        m_best = 0;
    endtask

    task automatic model_apply(input bit st, input bit v, input logic [255:0] bm);
        int raw [NS];
        int c0, c1, p0;
        bit all_hi;
        if (st) begin
            model_reset();
        end else if (v) begin
            all_hi = 1'b1;
            for (int j = 0; j < NS; j++) begin
                p0 = (2 * j) % NS;
                c0 = m_pm[p0] + int'(bm[4*j +: 2]);
                c1 = m_pm[p0 + 1] + int'(bm[4*j+2 +: 2]);
                if (c0 > MAXPM) c0 = MAXPM;
                if (c1 > MAXPM) c1 = MAXPM;
                raw[j]   = (c1 < c0) ? c1 : c0;
                m_dec[j] = (c1 < c0);
                if (raw[j] < HALF) all_hi = 1'b0;
            end
            m_best = 0;
            for (int j = 0; j < NS; j++) begin
                m_pm[j] = all_hi ? raw[j] - HALF : raw[j];
                if (m_pm[j] < m_pm[m_best]) m_best = j;
            end
            m_dv = 1'b1;
            m_np = all_hi;
        end else begin
            m_dv = 1'b0;
            m_np = 1'b0;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_dec_valid"},  BUS_W'(dec_valid),  BUS_W'(m_dv));
        check({tag, "_dec"},        BUS_W'(dec),        BUS_W'(m_dec));
        check({tag, "_norm_pulse"}, BUS_W'(norm_pulse), BUS_W'(m_np));
        check({tag, "_pm_bus"},     pm_bus,             model_bus());
`ifdef ACS_BEST_STATE_EN
        check({tag, "_best_state"}, BUS_W'(best_state), BUS_W'(m_best));
`endif
    endtask

    task automatic drive(input bit st, input bit v, input logic [255:0] bm);
        @(negedge clk);
        start    = st;
        bm_valid = v;
        bm_bus   = bm;
        @(posedge clk);
        #1;
        model_apply(st, v, bm);
    endtask

    function automatic logic [255:0] rand_bm();
        logic [255:0] r;
        for (int k = 0; k < 8; k++)
            r[32*k +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        logic [255:0] bm_zero, bm_b0two, bm_two, bm;
        int pulses, min_pm;
        bit st, v;

        bm_zero  = '0;
        bm_b0two = {64{4'h2}};
        bm_two   = {64{4'hA}};

        //             st v  bm        dv  dec                     np  pm0 pm1 pm32
        tbl[0] = '{1'b0, 1'b1, bm_zero,  1'b1, 64'h0,                  1'b0, 0, 16, 0};
        tbl[1] = '{1'b1, 1'b1, bm_two,   1'b0, 64'h0,                  1'b0, 0, 16, 16};
        tbl[2] = '{1'b0, 1'b1, bm_b0two, 1'b1, 64'hFFFF_FFFE_FFFF_FFFE, 1'b0, 2, 16, 2};
        tbl[3] = '{1'b0, 1'b0, bm_two,   1'b0, 64'hFFFF_FFFE_FFFF_FFFE, 1'b0, 2, 16, 2};
        tbl[4] = '{1'b0, 1'b0, bm_zero,  1'b0, 64'hFFFF_FFFE_FFFF_FFFE, 1'b0, 2, 16, 2};
        tbl[5] = '{1'b0, 1'b1, bm_zero,  1'b1, 64'h0,                  1'b0, 2, 16, 2};
        tbl[6] = '{1'b1, 1'b1, bm_b0two, 1'b0, 64'h0,                  1'b0, 0, 16, 16};

        rst      = 1'b1;
        start    = 1'b0;
        bm_valid = 1'b0;
        bm_bus   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        @(negedge clk);
        rst = 1'b0;

        // Directed table: all-zero step, start, bm0=2 step, idle hold, restart mid-frame.
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].st, tbl[i].v, tbl[i].bm);
            check($sformatf("tbl%0d_dec_valid", i),  BUS_W'(dec_valid),  BUS_W'(tbl[i].exp_dv));
            check($sformatf("tbl%0d_dec", i),        BUS_W'(dec),        BUS_W'(tbl[i].exp_dec));
            check($sformatf("tbl%0d_norm_pulse", i), BUS_W'(norm_pulse), BUS_W'(tbl[i].exp_np));
            check($sformatf("tbl%0d_pm0", i),  BUS_W'(dut_pm(0)),  BUS_W'(tbl[i].pm0));
            check($sformatf("tbl%0d_pm1", i),  BUS_W'(dut_pm(1)),  BUS_W'(tbl[i].pm1));
            check($sformatf("tbl%0d_pm32", i), BUS_W'(dut_pm(32)), BUS_W'(tbl[i].pm32));
            check_model($sformatf("tbl%0d", i));
        end

        // Constant bm=2: the minimum reaches 64 on step 32, so 40 steps give exactly one normalization.
        drive(1'b1, 1'b0, bm_zero);
        pulses = 0;
        for (int s = 0; s < 40; s++) begin
            drive(1'b0, 1'b1, bm_two);
            check_model($sformatf("norm%0d", s));
            if (norm_pulse) begin
                pulses++;
                min_pm = MAXPM;
                for (int j = 0; j < NS; j++)
                    if (dut_pm(j) < min_pm) min_pm = dut_pm(j);
                check("norm_min_after_drop", BUS_W'(min_pm), BUS_W'(0));
            end
        end
        check("norm_pulse_count", BUS_W'(pulses), BUS_W'(1));

        // Random steps, occasional restarts.
        for (int s = 0; s < 400; s++) begin
            st = ($urandom_range(0, 31) == 0);
            v  = ($urandom_range(0, 3) != 0);
            drive(st, v, rand_bm());
            check_model($sformatf("rnd%0d", s));
        end

        // Asynchronous reset between edges with a step pending: outputs return to reset values at once.
        @(negedge clk);
        bm_valid = 1'b1;
        bm_bus   = rand_bm();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_model("async_rst");
        @(posedge clk);
        #1;
        check_model("async_rst_held");
        @(negedge clk);
        rst      = 1'b0;
        bm_valid = 1'b0;
        drive(1'b0, 1'b1, bm_b0two);
        check_model("after_rst");

`ifdef ACS_BEST_STATE_EN
        // Zero-error stream: the 0->0 branch always costs 0, so state 0 stays best with metric 0.
        drive(1'b1, 1'b0, bm_zero);
        for (int s = 0; s < 20; s++) begin
            bm = rand_bm();
            bm[1:0] = 2'b00;
            drive(1'b0, 1'b1, bm);
            check($sformatf("zero_seq%0d_best", s), BUS_W'(best_state), BUS_W'(0));
            check($sformatf("zero_seq%0d_pm0", s),  BUS_W'(dut_pm(0)),  BUS_W'(0));
            check_model($sformatf("zero_seq%0d", s));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
